counter_0to19_ctrl: RTL

COUNTER_0TO19_CTRL -- requirements
Module: counter_0to19_ctrl

---
 rtl/counter_pkg.sv | 13 +
 rtl/rise_detect.sv | 19 +
 rtl/counter_0to19_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the 0..19 stopwatch counter: FSM state encoding
// and the default wrap point.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int unsigned MAX_COUNT_DEFAULT = 19;

endpackage

// File: rtl/rise_detect.sv
// Turns a debounced button level into a single-cycle press pulse.
// The pulse is combinational so it fires on the edge where the level is first sampled high.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/counter_0to19_ctrl.sv
// Start/pause/clear controlled BCD counter that steps once every TICK_DIV
// clocks and wraps from MAX_COUNT back to 00.
module counter_0to19_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       wrap_pulse
);

  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       running_q, running_d;
  logic       wrap_q, wrap_d;
  logic       start_ev, clear_ev;
  logic       tick;

  rise_detect u_start_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (btn_start),
    .pulse_o (start_ev)
  );

  rise_detect u_clear_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (btn_clear),
    .pulse_o (clear_ev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= 8'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    wrap_d  = 1'b0;

    if (clear_ev) begin
      state_d = IDLE;
      div_d   = 8'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_ev) begin
            state_d = RUN;
            div_d   = 8'd0;
          end
        end
        RUN: begin
          // A pause press freezes the divider unless it lands on the terminal count.
          if (tick) begin
            div_d = 8'd0;
            if (tens_q == MAX_TENS && ones_q == MAX_ONES) begin
              tens_d = 4'd0;
              ones_d = 4'd0;
              wrap_d = 1'b1;
            end else if (ones_q == 4'd9) begin
              ones_d = 4'd0;
              tens_d = tens_q + 4'd1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end else if (!start_ev) begin
            div_d = div_q + 8'd1;
          end
          if (start_ev) state_d = PAUSE;
        end
        PAUSE: begin
          if (start_ev) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  assign tens       = tens_q;
  assign ones       = ones_q;
  assign running    = running_q;
  assign wrap_pulse = wrap_q;

endmodule
